mhpm_counter_bank: RTL

MHPM_COUNTER_BANK -- requirements
Module: mhpm_counter_bank

---
 rtl/mhpm_counter_bank.sv | 139 +++++++++++++
 1 files changed

// File: rtl/mhpm_counter_bank.sv
// mhpm_counter_bank: bank of mhpmcounter/mhpmevent CSRs with mcountinhibit; define MHPM_OVF_IRQ_EN for overflow flags and interrupt
module mhpm_counter_bank #(
    parameter int          NUM_MHPM               = 4,
    parameter int          NUM_EVENTS             = 24,
    parameter int          CNT_SZ                 = 64,
    parameter bit          SET_MCOUNTINHIBIT      = 1'b0,
    parameter logic [31:0] SET_MCOUNTINHIBIT_BITS = 32'h0
) (
    input  logic                  clk_in,
    input  logic                  reset_in,
    input  logic [NUM_EVENTS-1:0] events_in,
    input  logic                  csr_wr,
    input  logic [11:0]           csr_wr_addr,
    input  logic [31:0]           csr_wr_data,
    input  logic [11:0]           csr_rd_addr,
    output logic [31:0]           csr_rd_data,
    output logic                  csr_rd_hit,
    output logic                  ovf_irq_out
);
    localparam int          EV_SEL_SZ = NUM_EVENTS > 1 ? $clog2(NUM_EVENTS) : 1;
    localparam int          EV_N      = 1 << EV_SEL_SZ;
    localparam logic [31:0] INH_MASK  = 32'(((64'd1 << NUM_MHPM) - 64'd1) << 3);

    // Event vector padded to every selector code; code 0 and codes >= NUM_EVENTS never fire
    logic [EV_N-1:0]                      ev_vec;
    logic [31:0]                          inh;
    logic [NUM_MHPM-1:0][CNT_SZ-1:0]      cnt;
    logic [NUM_MHPM-1:0][EV_SEL_SZ-1:0]   evsel;
    logic [NUM_MHPM-1:0]                  inc;
    logic [NUM_MHPM-1:0]                  wr_cnt;

    assign ev_vec = EV_N'(events_in) & ~EV_N'(1);

    for (genvar i = 0; i < NUM_MHPM; i++) begin : g_cnt
        localparam logic [11:0] LO = 12'(12'hB03 + i);
        localparam logic [11:0] HI = 12'(12'hB83 + i);
        localparam logic [11:0] EV = 12'(12'h323 + i);
        logic                 wr_lo;
        logic                 wr_hi;
        logic [CNT_SZ-1:0]    c;
        logic [EV_SEL_SZ-1:0] s;
        assign wr_lo     = csr_wr && csr_wr_addr == LO;
        assign wr_hi     = csr_wr && csr_wr_addr == HI;
        assign wr_cnt[i] = wr_lo | wr_hi;
        assign inc[i]    = ev_vec[s] & ~inh[3+i];
        assign cnt[i]    = c;
        assign evsel[i]  = s;
        // Counter and selector update; a CSR write to the counter drops that cycle's increment
        always_ff @(posedge clk_in or posedge reset_in) begin
            if (reset_in) begin
                c <= '0;
                s <= '0;
            end else begin
                if (wr_lo)
                    c[31:0] <= csr_wr_data;
                else if (wr_hi)
                    c[CNT_SZ-1:32] <= csr_wr_data[CNT_SZ-33:0];
                else if (inc[i])
                    c <= c + 1'b1;
                if (csr_wr && csr_wr_addr == EV)
                    s <= csr_wr_data[EV_SEL_SZ-1:0];
            end
        end
    end

    if (SET_MCOUNTINHIBIT) begin : g_inh_const
        assign inh = SET_MCOUNTINHIBIT_BITS & INH_MASK;
    end else begin : g_inh_reg
        logic [31:0] inh_q;
        assign inh = inh_q;
        // Writable inhibit register holding only the implemented counter bits
        always_ff @(posedge clk_in or posedge reset_in) begin
            if (reset_in)
                inh_q <= '0;
            else if (csr_wr && csr_wr_addr == 12'h320)
                inh_q <= csr_wr_data & INH_MASK;
        end
    end

`ifdef MHPM_OVF_IRQ_EN
    logic [NUM_MHPM-1:0] ovf;
    logic [NUM_MHPM-1:0] ovf_clr;
    logic [NUM_MHPM-1:0] wrap;
    logic                ovf_irq;

    assign ovf_clr     = (csr_wr && csr_wr_addr == 12'h7C0) ? csr_wr_data[NUM_MHPM-1:0] : '0;
    assign ovf_irq_out = ovf_irq;

    // A counter wraps only when it actually increments from all-ones
    always_comb begin
        wrap = '0;
        for (int k = 0; k < NUM_MHPM; k++)
            wrap[k] = inc[k] && !wr_cnt[k] && (&cnt[k]);
    end

    // Sticky flags, write-1-to-clear with set priority; interrupt is the registered OR of the flags
    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            ovf     <= '0;
            ovf_irq <= 1'b0;
        end else begin
            ovf     <= (ovf & ~ovf_clr) | wrap;
            ovf_irq <= |ovf;
        end
    end
`else
    assign ovf_irq_out = 1'b0;
`endif

    // Combinational CSR read decode
    always_comb begin
        csr_rd_data = '0;
        csr_rd_hit  = 1'b0;
        if (csr_rd_addr == 12'h320) begin
            csr_rd_hit  = 1'b1;
            csr_rd_data = inh;
        end
`ifdef MHPM_OVF_IRQ_EN
        if (csr_rd_addr == 12'h7C0) begin
            csr_rd_hit  = 1'b1;
            csr_rd_data = 32'(ovf);
        end
`endif
        for (int k = 0; k < NUM_MHPM; k++) begin
            if (csr_rd_addr == 12'(12'hB03 + k)) begin
                csr_rd_hit  = 1'b1;
                csr_rd_data = cnt[k][31:0];
            end
            if (csr_rd_addr == 12'(12'hB83 + k)) begin
                csr_rd_hit  = 1'b1;
                csr_rd_data = 32'(cnt[k][CNT_SZ-1:32]);
            end
            if (csr_rd_addr == 12'(12'h323 + k)) begin
                csr_rd_hit  = 1'b1;
                csr_rd_data = 32'(evsel[k]);
            end
        end
    end
endmodule
